hilo_muldiv_ctrl: RTL

HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

---
 rtl/hilo_muldiv_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register control for MIPS-style multiply, divide and move-to-HI/LO.
// Multiplies complete at the accept edge; divides run a 32-cycle restoring sequence.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        req_ready,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_e;

  localparam logic [5:0] OP_DIV   = 6'b100000;
  localparam logic [5:0] OP_DIVU  = 6'b010000;
  localparam logic [5:0] OP_MULT  = 6'b001000;
  localparam logic [5:0] OP_MULTU = 6'b000100;
  localparam logic [5:0] OP_MTHI  = 6'b000010;
  localparam logic [5:0] OP_MTLO  = 6'b000001;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_s;

  logic        is_signed_div_s;
  logic        is_signed_mul_s;
  logic [31:0] mag1_s;
  logic [31:0] mag2_s;
  logic [63:0] ext1_s;
  logic [63:0] ext2_s;
  logic [63:0] prod_s;
  logic [33:0] trial_s;
  logic        take_s;
  logic [31:0] rem_step_s;
  logic [31:0] quo_step_s;

  // Operand conditioning, multiply datapath and one restoring-division step
  always_comb begin
    is_signed_div_s = (req_op == OP_DIV);
    is_signed_mul_s = (req_op == OP_MULT);
    mag1_s = (is_signed_div_s && req_src1[31]) ? (32'd0 - req_src1) : req_src1;
    mag2_s = (is_signed_div_s && req_src2[31]) ? (32'd0 - req_src2) : req_src2;
    ext1_s = {(is_signed_mul_s ? {32{req_src1[31]}} : 32'd0), req_src1};
    ext2_s = {(is_signed_mul_s ? {32{req_src2[31]}} : 32'd0), req_src2};
    prod_s = ext1_s * ext2_s;
    // A zero divisor always "takes", which yields quotient all-ones and remainder = dividend.
    trial_s    = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};
    take_s     = ~trial_s[33];
    rem_step_s = take_s ? trial_s[31:0] : {rem_q[30:0], quo_q[31]};
    quo_step_s = {quo_q[30:0], take_s};
  end

  // Next-state, HI/LO update and done generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (req_valid) begin
          case (req_op)
            OP_DIV, OP_DIVU: begin
              quo_d   = mag1_s;
              dvs_d   = mag2_s;
              rem_d   = 32'd0;
              cnt_d   = 5'd0;
              qneg_d  = is_signed_div_s & (req_src1[31] ^ req_src2[31]);
              rneg_d  = is_signed_div_s & req_src1[31];
              state_d = ST_DIV;
            end
            OP_MULT, OP_MULTU: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OP_MTHI: hi_d = req_src1;
            OP_MTLO: lo_d = req_src1;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          quo_d = quo_step_s;
          rem_d = rem_step_s;
          if (cnt_q == 5'd31) begin
            done_s  = 1'b1;
            state_d = ST_IDLE;
            lo_d    = qneg_q ? (32'd0 - quo_step_s) : quo_step_s;
            hi_d    = rneg_q ? (32'd0 - rem_step_s) : rem_step_s;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_DIV);
  assign done      = done_s;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
